hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller: load-use/RAW interlock, taken-branch
// flush, and memory-wait freeze with a timeout abort.
module hazard_stall_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [3:0]  id_src1,
   input  logic [3:0]  id_src2,
   input  logic        id_two_src,
   input  logic [3:0]  ex_dst,
   input  logic        ex_wb_en,
   input  logic        ex_mem_read,
   input  logic [3:0]  mem_dst,
   input  logic        mem_wb_en,
   input  logic        fwd_en,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_freeze,
   output logic        ifid_freeze,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        idex_freeze,
   output logic        exmem_freeze,
   output logic        mem_timeout,
   output logic [15:0] stall_cnt
);

   // state    | meaning
   // RUN      | normal issue; resolves memory wait > branch > hazard
   // MEM_WAIT | whole pipe frozen until mem_ready or the wait counter hits TIMEOUT
   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       timeout_set;
   logic       raw_ex, raw_mem, hazard;

   assign raw_ex  = ex_wb_en  && ((id_src1 == ex_dst)  || (id_two_src && (id_src2 == ex_dst)));
   assign raw_mem = mem_wb_en && ((id_src1 == mem_dst) || (id_two_src && (id_src2 == mem_dst)));
   // With forwarding only a load in EX cannot be bypassed; without it any producer in flight stalls.
   assign hazard  = id_valid && (fwd_en ? (raw_ex && ex_mem_read) : (raw_ex || raw_mem));

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_set  = 1'b0;
      pc_freeze    = 1'b0;
      ifid_freeze  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      idex_freeze  = 1'b0;
      exmem_freeze = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               wait_cnt_nxt = 8'd0;
               if (mem_req && !mem_ready) begin
                  pc_freeze    = 1'b1;
                  ifid_freeze  = 1'b1;
                  idex_freeze  = 1'b1;
                  exmem_freeze = 1'b1;
                  state_nxt    = MEM_WAIT;
               end else if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (hazard) begin
                  pc_freeze   = 1'b1;
                  ifid_freeze = 1'b1;
                  idex_flush  = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = 8'd0;
               end else if (wait_cnt == TIMEOUT_W) begin
                  // Abort: release the pipe this cycle and flag the lost access.
                  timeout_set  = 1'b1;
                  state_nxt    = RUN;
                  wait_cnt_nxt = 8'd0;
               end else begin
                  pc_freeze    = 1'b1;
                  ifid_freeze  = 1'b1;
                  idex_freeze  = 1'b1;
                  exmem_freeze = 1'b1;
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
         stall_cnt   <= 16'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_set) mem_timeout <= 1'b1;
         if (pc_freeze && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus queues per-cycle expected
// freeze/flush, timeout flag and stall count; a negedge monitor checks them.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
   logic        fwd_en, branch_taken, mem_req, mem_ready;
   logic [3:0]  id_src1, id_src2, ex_dst, mem_dst;
   logic        pc_freeze, ifid_freeze, ifid_flush, idex_flush, idex_freeze, exmem_freeze;
   logic        mem_timeout;
   logic [15:0] stall_cnt;

   hazard_stall_ctrl dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
      .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .idex_freeze(idex_freeze), .exmem_freeze(exmem_freeze),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // {pc_freeze, ifid_freeze, ifid_flush, idex_flush, idex_freeze, exmem_freeze}
   localparam logic [5:0] F_NONE = 6'b000000;
   localparam logic [5:0] F_MEM  = 6'b110011;
   localparam logic [5:0] F_BR   = 6'b001100;
   localparam logic [5:0] F_HZ   = 6'b110100;

   typedef struct {
      int          cyc;
      string       name;
      logic [5:0]  ctl;
      logic        to;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   cyc_n = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_valid = 0; id_two_src = 0; ex_wb_en = 0; ex_mem_read = 0; mem_wb_en = 0;
      fwd_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
      id_src1 = 0; id_src2 = 0; ex_dst = 0; mem_dst = 0;
   endtask

   task automatic load_use();
      fwd_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dst = 4'd3; id_src1 = 4'd3; id_valid = 1;
   endtask

   task automatic expect_now(input string nm, input logic [5:0] c, input logic t, input logic [15:0] s);
      exp_t e;
      e.cyc = cyc_n; e.name = nm; e.ctl = c; e.to = t; e.cnt = s;
      q.push_back(e);
   endtask

   // Monitor: every cycle checks the freeze/flush exclusivity, and the
   // scoreboard entry queued for this cycle, if any.
   always @(negedge clk) begin
      exp_t e;
      logic [5:0] act;
      act = {pc_freeze, ifid_freeze, ifid_flush, idex_flush, idex_freeze, exmem_freeze};
      n_checks++;
      if ((ifid_freeze && ifid_flush) || (idex_freeze && idex_flush)) begin
         n_errors++;
         $display("FAIL excl cyc=%0d ctl=%b required no freeze+flush pair", cyc_n, act);
      end
      while (q.size() > 0 && q[0].cyc < cyc_n) begin
         e = q.pop_front();
         n_checks++; n_errors++;
         $display("FAIL %s stale entry cyc=%0d now=%0d", e.name, e.cyc, cyc_n);
      end
      if (q.size() > 0 && q[0].cyc == cyc_n) begin
         e = q.pop_front();
         n_checks += 3;
         if (act !== e.ctl) begin
            n_errors++;
            $display("FAIL %s ctl got=%b exp=%b", e.name, act, e.ctl);
         end
         if (mem_timeout !== e.to) begin
            n_errors++;
            $display("FAIL %s mem_timeout got=%b exp=%b", e.name, mem_timeout, e.to);
         end
         if (stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt);
         end
      end
   end

   initial begin
      #2_000_000;
      if (!done) begin
         $display("FAIL watchdog time limit expired");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      clr_in();
      rst = 1'b1;
      // reset forces everything low even with stall/mem inputs active
      tick(); load_use(); mem_req = 1; expect_now("reset", F_NONE, 1'b0, 16'd0);
      tick(); rst = 1'b0; clr_in(); expect_now("post_reset", F_NONE, 1'b0, 16'd0);

      tick(); load_use(); expect_now("load_use", F_HZ, 1'b0, 16'd0);
      tick(); clr_in(); expect_now("load_use_cnt", F_NONE, 1'b0, 16'd1);
      tick(); fwd_en = 1; ex_wb_en = 1; ex_dst = 4'd3; id_src1 = 4'd3; id_valid = 1;
      expect_now("fwd_alu_no_stall", F_NONE, 1'b0, 16'd1);
      tick(); clr_in(); mem_wb_en = 1; mem_dst = 4'd5; id_two_src = 1; id_src2 = 4'd5; id_valid = 1;
      expect_now("raw_mem_src2", F_HZ, 1'b0, 16'd1);
      tick(); id_two_src = 0; expect_now("raw_mem_one_src", F_NONE, 1'b0, 16'd2);
      tick(); clr_in(); ex_wb_en = 1; ex_dst = 4'd7; id_two_src = 1; id_src2 = 4'd7; id_src1 = 4'd2; id_valid = 1;
      expect_now("raw_ex_nofwd", F_HZ, 1'b0, 16'd2);
      tick(); id_valid = 0; expect_now("invalid_id", F_NONE, 1'b0, 16'd3);
      tick(); clr_in(); load_use(); branch_taken = 1; expect_now("branch_over_hazard", F_BR, 1'b0, 16'd3);
      tick(); clr_in(); mem_req = 1; mem_ready = 1; expect_now("mem_hit", F_NONE, 1'b0, 16'd3);

      tick(); mem_ready = 0; expect_now("mem_wait_enter", F_MEM, 1'b0, 16'd3);
      tick(); clr_in(); expect_now("mem_wait_1", F_MEM, 1'b0, 16'd4);
      tick(); load_use(); branch_taken = 1; expect_now("mem_wait_ignore", F_MEM, 1'b0, 16'd5);
      tick(); clr_in(); expect_now("mem_wait_3", F_MEM, 1'b0, 16'd6);
      tick(); mem_ready = 1; expect_now("mem_ready", F_NONE, 1'b0, 16'd7);
      tick(); clr_in(); branch_taken = 1; expect_now("back_in_run", F_BR, 1'b0, 16'd7);

      tick(); clr_in(); mem_req = 1; expect_now("to_enter", F_MEM, 1'b0, 16'd7);
      for (int k = 1; k <= 255; k++) begin
         tick(); clr_in();
         if (k == 1 || k == 128 || k == 255) expect_now("to_wait", F_MEM, 1'b0, 16'(7 + k));
      end
      tick(); expect_now("to_abort", F_NONE, 1'b0, 16'd263);
      tick(); branch_taken = 1; expect_now("to_flag_run", F_BR, 1'b1, 16'd263);
      tick(); clr_in(); mem_req = 1; expect_now("to_sticky_wait", F_MEM, 1'b1, 16'd263);
      tick(); clr_in(); mem_ready = 1; expect_now("to_sticky_ready", F_NONE, 1'b1, 16'd264);
      tick(); clr_in(); expect_now("to_sticky_idle", F_NONE, 1'b1, 16'd264);

      tick(); mem_req = 1; expect_now("rst_wait_enter", F_MEM, 1'b1, 16'd264);
      tick(); clr_in(); expect_now("rst_wait_1", F_MEM, 1'b1, 16'd265);
      tick(); rst = 1'b1; branch_taken = 1; expect_now("rst_mid_wait", F_NONE, 1'b0, 16'd0);
      tick(); rst = 1'b0; expect_now("rst_back_run", F_BR, 1'b0, 16'd0);

      tick(); clr_in(); load_use();
      for (int i = 0; i <= 65536; i++) begin
         if (i == 0 || i == 65534 || i == 65535 || i == 65536)
            expect_now("sat", F_HZ, 1'b0, (i > 65535) ? 16'hFFFF : 16'(i));
         if (i != 65536) tick();
      end
      tick(); clr_in(); expect_now("sat_hold", F_NONE, 1'b0, 16'hFFFF);

      tick(); tick();
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
